i2s_audio_tx: RTL

Parametrised I2S playback transmitter for the on-board audio codec. It drives the AC_MCLK, AC_BCLK, AC_PBLRC, AC_SDATA_O and AC_MUTE_N pins, which the current top level only ties off. Stereo sample pairs arrive on a valid/ready stream from PL logic or DMA and are buffered in a small FIFO. The block generates all codec clocks from the fabric clock, shifts frames out in I2S format, and flags underruns.

---
 rtl/i2s_audio_tx.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/i2s_audio_tx.sv
// rtl/i2s_audio_tx.sv - I2S playback transmitter with sample-pair FIFO
//
// Purpose:
//   Buffers stereo sample pairs in a small FIFO and shifts them out to the
//   audio codec in I2S format (MSB one BCLK after the LRCLK edge). All codec
//   clocks are derived from the fabric clock. A frame due while the FIFO is
//   empty goes out as silence and raises a sticky underrun flag.
//
// Ports:
//   clk, rst          fabric clock, asynchronous active-high reset
//   enable            run transmitter; low = idle and muted
//   s_valid/s_ready   sample-pair stream handshake (s_ready = !full)
//   s_left/s_right    two's complement samples
//   fifo_level        entries currently held
//   underrun          sticky underrun flag, cleared by underrun_clr
//   ac_mclk           free-running codec master clock
//   ac_bclk           bit clock
//   ac_pblrc          playback LR clock (0 = left)
//   ac_sdata_o        serial data
//   ac_mute_n         codec mute, active low

module i2s_audio_tx #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32,
  parameter int BCLK_DIV   = 8,
  parameter int MCLK_DIV   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [DATA_WIDTH-1:0]             s_left,
  input  logic [DATA_WIDTH-1:0]             s_right,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              underrun,
  input  logic                              underrun_clr,
  output logic                              ac_mclk,
  output logic                              ac_bclk,
  output logic                              ac_pblrc,
  output logic                              ac_sdata_o,
  output logic                              ac_mute_n
);

  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = 2 * DATA_WIDTH;
  localparam int BW = $clog2(BCLK_DIV);
  localparam int MW = $clog2(MCLK_DIV);
  localparam int PW = $clog2(2 * SLOT_WIDTH + 1);

  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  localparam logic [MW-1:0] MDIV_LAST  = MW'(MCLK_DIV - 1);
  localparam logic [MW-1:0] MDIV_HALF  = MW'(MCLK_DIV / 2);
  localparam logic [MW-1:0] MDIV_ONE   = MW'(1);

  localparam logic [BW-1:0] BDIV_LAST  = BW'(BCLK_DIV - 1);
  localparam logic [BW-1:0] BDIV_HALF  = BW'(BCLK_DIV / 2);
  localparam logic [BW-1:0] BDIV_ONE   = BW'(1);

  localparam logic [PW-1:0] P_ONE      = PW'(1);
  localparam logic [PW-1:0] P_LAST     = PW'(2 * SLOT_WIDTH - 1);
  localparam logic [PW-1:0] P_SLOT     = PW'(SLOT_WIDTH);
  localparam logic [PW-1:0] P_L_END    = PW'(DATA_WIDTH);
  localparam logic [PW-1:0] P_R_FIRST  = PW'(SLOT_WIDTH + 1);
  localparam logic [PW-1:0] P_R_END    = PW'(SLOT_WIDTH + DATA_WIDTH);

  // With full-width samples the right LSB spills into p=0 of the next frame.
  localparam bit SPILL = (DATA_WIDTH == SLOT_WIDTH);

  // FIFO state
  logic [FW-1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wptr_q, wptr_d;
  logic [AW-1:0]  rptr_q, rptr_d;
  logic [LW-1:0]  level_q, level_d;
  logic           full, empty, push, pop;

  // Clock generation and bit timing state
  logic [MW-1:0]  mcnt_q, mcnt_d;
  logic           mclk_q, mclk_d;
  logic [BW-1:0]  bdiv_q, bdiv_d;
  logic [PW-1:0]  p_q, p_d;
  logic           run_q;
  logic           bit_start, frame_start, in_data;

  // Frame shift register; after the last right bit its MSB holds the
  // spilled right LSB, which doubles as the carry into the next frame.
  logic [FW-1:0]  sh_q, sh_d;
  logic           bclk_q, bclk_d;
  logic           lrc_q, lrc_d;
  logic           sdata_q, sdata_d;
  logic           underrun_q, underrun_d;

  assign full       = (level_q == LEVEL_FULL);
  assign empty      = (level_q == '0);
  assign push       = s_valid && !full;
  // Pop decision uses the registered level, so a same-cycle push into an
  // empty FIFO is never seen by this frame.
  assign pop        = frame_start && !empty;

  // The first enabled edge after idle always restarts at p=0, bdiv=0.
  assign bit_start   = enable && (!run_q || (bdiv_q == BDIV_LAST));
  assign frame_start = enable && (!run_q || ((bdiv_q == BDIV_LAST) && (p_q == P_LAST)));

  always_comb begin
    mcnt_d = (mcnt_q == MDIV_LAST) ? '0 : mcnt_q + MDIV_ONE;
    mclk_d = (mcnt_d >= MDIV_HALF);
  end

  always_comb begin
    wptr_d  = push ? wptr_q + PTR_ONE : wptr_q;
    rptr_d  = pop  ? rptr_q + PTR_ONE : rptr_q;
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LEVEL_ONE;
      2'b01:   level_d = level_q - LEVEL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    bdiv_d = '0;
    p_d    = '0;
    if (enable && run_q) begin
      if (bdiv_q == BDIV_LAST) begin
        bdiv_d = '0;
        p_d    = (p_q == P_LAST) ? '0 : p_q + P_ONE;
      end else begin
        bdiv_d = bdiv_q + BDIV_ONE;
        p_d    = p_q;
      end
    end
  end

  assign in_data = ((p_d >= P_ONE) && (p_d <= P_L_END)) ||
                   ((p_d >= P_R_FIRST) && (p_d <= P_R_END));

  always_comb begin
    sh_d       = sh_q;
    bclk_d     = 1'b0;
    lrc_d      = 1'b0;
    sdata_d    = 1'b0;
    if (enable) begin
      bclk_d  = (bdiv_d >= BDIV_HALF);
      lrc_d   = lrc_q;
      sdata_d = sdata_q;
      if (frame_start) begin
        sh_d    = pop ? mem_q[rptr_q] : '0;
        lrc_d   = 1'b0;
        // Spilled right LSB of the previous frame; 0 on the first frame
        // after enable because nothing was sent yet.
        sdata_d = SPILL && run_q && sh_q[FW-1];
      end else if (bit_start) begin
        lrc_d   = (p_d >= P_SLOT);
        sdata_d = in_data && sh_q[FW-1];
        if (in_data) begin
          sh_d = sh_q << 1;
        end
      end
    end
  end

  // Set wins over clear.
  always_comb begin
    underrun_d = underrun_q;
    if (frame_start && empty) begin
      underrun_d = 1'b1;
    end else if (underrun_clr) begin
      underrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= {s_left, s_right};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      mcnt_q     <= '0;
      mclk_q     <= 1'b0;
      bdiv_q     <= '0;
      p_q        <= '0;
      run_q      <= 1'b0;
      sh_q       <= '0;
      bclk_q     <= 1'b0;
      lrc_q      <= 1'b0;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      mcnt_q     <= mcnt_d;
      mclk_q     <= mclk_d;
      bdiv_q     <= bdiv_d;
      p_q        <= p_d;
      run_q      <= enable;
      sh_q       <= sh_d;
      bclk_q     <= bclk_d;
      lrc_q      <= lrc_d;
      sdata_q    <= sdata_d;
      underrun_q <= underrun_d;
    end
  end

  assign s_ready    = !full;
  assign fifo_level = level_q;
  assign underrun   = underrun_q;
  assign ac_mclk    = mclk_q;
  assign ac_bclk    = bclk_q;
  assign ac_pblrc   = lrc_q;
  assign ac_sdata_o = sdata_q;
  assign ac_mute_n  = run_q;

endmodule
